muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Takes a Start/Busy/Done handshake and produces the M-extension result a
// fixed Width+1 cycles after the accepting Start edge.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   op1_i      rs1 operand (multiplicand / dividend)
//   op2_i      rs2 operand (multiplier / divisor)
//   funct3_i   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   start_i    request, sampled only while idle
//   busy_o     operation in progress
//   done_o     one-cycle pulse, result_o valid
//   result_o   registered result, held until the next done_o
module muldiv_unit #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] op1_i,
    input  logic [Width-1:0] op2_i,
    input  logic [2:0]       funct3_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] result_o
);

    localparam int unsigned CntW = $clog2(Width + 1);
    localparam int unsigned AccW = 2 * Width;

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       funct3_q;
    logic             neg_q;
    // Multiplicand for multiply, divisor for divide.
    logic [Width-1:0] opb_q;
    // Multiply: {product high, multiplier/product low}. Divide: low half is
    // the dividend being shifted out and the quotient being shifted in.
    logic [AccW-1:0]  acc_q;
    logic [Width:0]   rem_q;
    logic             busy_q;
    logic             done_q;
    logic [Width-1:0] result_q;

    // Start-time operand decode.
    logic             sgn1, sgn2, neg1, neg2, neg_start;
    logic [Width-1:0] mag1, mag2;

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (funct3_i)
            3'b001, 3'b100, 3'b110: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            3'b010:  sgn1 = 1'b1;
            default: ;
        endcase
        neg1 = sgn1 & op1_i[Width-1];
        neg2 = sgn2 & op2_i[Width-1];
        mag1 = neg1 ? -op1_i : op1_i;
        mag2 = neg2 ? -op2_i : op2_i;
        if (!funct3_i[2]) begin
            neg_start = neg1 ^ neg2;
        end else if (funct3_i[1]) begin
            // Remainder follows the dividend.
            neg_start = neg1;
        end else begin
            // Divide by zero returns all ones, never negated.
            neg_start = (neg1 ^ neg2) & (|op2_i);
        end
    end

    // One iteration of shift-add multiply and restoring divide.
    logic [Width:0]   mul_sum;
    logic [AccW-1:0]  mul_next;
    logic [Width:0]   div_trial;
    logic             div_ge;
    logic [Width:0]   div_rem;
    logic [Width-1:0] div_quo;

    always_comb begin
        mul_sum   = {1'b0, acc_q[AccW-1:Width]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[Width-1:1]};
        div_trial = {rem_q[Width-1:0], acc_q[Width-1]};
        div_ge    = div_trial >= {1'b0, opb_q};
        div_rem   = div_ge ? div_trial - {1'b0, opb_q} : div_trial;
        div_quo   = {acc_q[Width-2:0], div_ge};
    end

    // A restored remainder is always below the divisor, so its top bit stays clear.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[Width];

    // Sign correction and result select.
    logic [AccW-1:0]  prod_fix;
    logic [Width-1:0] quo_fix, rem_fix, fin_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[Width-1:0] : acc_q[Width-1:0];
        rem_fix  = neg_q ? -rem_q[Width-1:0] : rem_q[Width-1:0];
        case (funct3_q)
            3'b000:                 fin_res = prod_fix[Width-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fix[AccW-1:Width];
            3'b100, 3'b101:         fin_res = quo_fix;
            default:                fin_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        funct3_q <= funct3_i;
                        neg_q    <= neg_start;
                        opb_q    <= funct3_i[2] ? mag2 : mag1;
                        acc_q    <= {{Width{1'b0}}, (funct3_i[2] ? mag1 : mag2)};
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    if (funct3_q[2]) begin
                        acc_q <= {{Width{1'b0}}, div_quo};
                        rem_q <= div_rem;
                    end else begin
                        acc_q <= mul_next;
                    end
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(Width - 1)) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    result_q <= fin_res;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
